// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with a retired-instruction counter.
// Load-use stall detection is built only when CTRL_PIPE_HAZARD_EN is defined.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_reg_dst,
  input  logic        id_jump,
  input  logic        id_branch,
  input  logic        id_mem_read,
  input  logic        id_mem_to_reg,
  input  logic        id_mem_write,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic [1:0]  id_alu_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic        ex_valid,
  output logic        ex_alu_src,
  output logic        ex_reg_dst,
  output logic [1:0]  ex_alu_op,
  output logic [4:0]  ex_dst,
  output logic        mem_valid,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_branch,
  output logic        mem_jump,
  output logic [4:0]  mem_dst,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_dst,
  output logic        hazard_stall,
  output logic [15:0] retired
);

  logic ex_load;
  logic ex_mem_read;
  logic ex_mem_write;
  logic ex_branch;
  logic ex_jump;
  logic ex_reg_write;
  logic ex_mem_to_reg;
  logic mem_reg_write;
  logic mem_mem_to_reg;

  // Any squash condition turns the EX load into an all-zero bubble.
  assign ex_load = id_valid & ~flush & ~hazard_stall;

`ifdef CTRL_PIPE_HAZARD_EN
  // Register 0 is hardwired, so a load into it can never create a dependency.
  assign hazard_stall = ex_valid & ex_mem_read & (ex_dst != 5'd0) & id_valid &
                        ((ex_dst == id_rs) | (ex_dst == id_rt));
`else
  logic unused_id_rs;
  assign unused_id_rs = ^id_rs;
  assign hazard_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_dst        <= 5'd0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      ex_valid      <= ex_load;
      ex_alu_src    <= ex_load & id_alu_src;
      ex_reg_dst    <= ex_load & id_reg_dst;
      ex_alu_op     <= ex_load ? id_alu_op : 2'b00;
      ex_dst        <= ex_load ? (id_reg_dst ? id_rd : id_rt) : 5'd0;
      ex_mem_read   <= ex_load & id_mem_read;
      ex_mem_write  <= ex_load & id_mem_write;
      ex_branch     <= ex_load & id_branch;
      ex_jump       <= ex_load & id_jump;
      ex_reg_write  <= ex_load & id_reg_write;
      ex_mem_to_reg <= ex_load & id_mem_to_reg;
    end
  end

  // Downstream stages never hold; gating on valid keeps bubbles inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_branch     <= 1'b0;
      mem_jump       <= 1'b0;
      mem_dst        <= 5'd0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
    end else begin
      mem_valid      <= ex_valid;
      mem_read       <= ex_valid & ex_mem_read;
      mem_write      <= ex_valid & ex_mem_write;
      mem_branch     <= ex_valid & ex_branch;
      mem_jump       <= ex_valid & ex_jump;
      mem_dst        <= ex_valid ? ex_dst : 5'd0;
      mem_reg_write  <= ex_valid & ex_reg_write;
      mem_mem_to_reg <= ex_valid & ex_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dst        <= 5'd0;
    end else begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_valid & mem_reg_write;
      wb_mem_to_reg <= mem_valid & mem_mem_to_reg;
      wb_dst        <= mem_valid ? mem_dst : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= 16'h0000;
    end else if (wb_valid) begin
      retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus pushes expected MEM/WB records,
// a negedge monitor pops them whenever the DUT presents a valid stage.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_HAZARD_EN
  localparam logic HAZ = 1'b1;
`else
  localparam logic HAZ = 1'b0;
`endif

  // control word order: reg_dst jump branch mem_read mem_to_reg mem_write alu_src reg_write
  localparam logic [7:0] C_R   = 8'b1000_0001;
  localparam logic [7:0] C_LW  = 8'b0001_1011;
  localparam logic [7:0] C_SW  = 8'b0000_0110;
  localparam logic [7:0] C_BEQ = 8'b0010_0000;
  localparam logic [7:0] C_J   = 8'b0100_0000;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    int         wb_cyc;
    logic [4:0] dst;
    logic       rw;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_reg_dst, id_jump, id_branch, id_mem_read;
  logic        id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]  id_alu_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic        ex_valid, ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_dst;
  logic        mem_valid, mem_read, mem_write, mem_branch, mem_jump;
  logic [4:0]  mem_dst;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_dst;
  logic        hazard_stall;
  logic [15:0] retired;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_jump(id_jump), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .hazard_stall(hazard_stall), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          n_issued = 0;
  exp_t        wb_q[$];
  exp_t        mem_q[$];
  logic [15:0] exp_ret = 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic instr_t mk(input logic [7:0] ctl, input logic [1:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
    return {ctl, op, rs, rt, rd};
  endfunction

  task automatic drive(input instr_t i, input logic v, input logic fl);
    id_valid      = v;
    id_reg_dst    = i.reg_dst;
    id_jump       = i.jump;
    id_branch     = i.branch;
    id_mem_read   = i.mem_read;
    id_mem_to_reg = i.mem_to_reg;
    id_mem_write  = i.mem_write;
    id_alu_src    = i.alu_src;
    id_reg_write  = i.reg_write;
    id_alu_op     = i.alu_op;
    id_rs         = i.rs;
    id_rt         = i.rt;
    id_rd         = i.rd;
    flush         = fl;
  endtask

  task automatic idle();
    drive(mk(8'h00, 2'b00, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
  endtask

  task automatic push(input instr_t i, input logic [4:0] dst, input int lat);
    exp_t e;
    e.wb_cyc = cyc + lat;
    e.dst    = dst;
    e.rw     = i.reg_write;
    e.m2r    = i.mem_to_reg;
    e.mr     = i.mem_read;
    e.mw     = i.mem_write;
    e.br     = i.branch;
    e.jp     = i.jump;
    wb_q.push_back(e);
    mem_q.push_back(e);
    n_issued++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    next_cycle();
    idle();
    repeat (n) next_cycle();
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, ex_valid, ex_alu_src, ex_reg_dst, ex_alu_op, ex_dst,
            mem_valid, mem_read, mem_write, mem_branch, mem_jump, mem_dst,
            wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst, hazard_stall, retired};
  endfunction

  // Load followed by a consumer; exp_haz says whether a dependency exists.
  task automatic load_use(input string nm, input instr_t ld, input logic [4:0] ld_dst,
                          input instr_t use_i, input logic [4:0] use_dst,
                          input logic exp_haz);
    logic stall_exp;
    stall_exp = HAZ & exp_haz;
    next_cycle();
    drive(ld, 1'b1, 1'b0);
    push(ld, ld_dst, 3);
    next_cycle();
    drive(use_i, 1'b1, 1'b0);
    push(use_i, use_dst, stall_exp ? 4 : 3);
    @(negedge clk);
    chk({nm, "_stall"}, hazard_stall, stall_exp);
    chk({nm, "_ex_ld"}, {ex_valid, ex_alu_src, ex_reg_dst, ex_alu_op, ex_dst},
        {1'b1, ld.alu_src, ld.reg_dst, ld.alu_op, ld_dst});
    next_cycle();
    if (!stall_exp) idle();
    @(negedge clk);
    chk({nm, "_ex_next"}, {ex_valid, ex_dst, hazard_stall},
        stall_exp ? {1'b0, 5'd0, 1'b0} : {1'b1, use_dst, 1'b0});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      wb_q.delete();
      mem_q.delete();
      exp_ret = 16'h0000;
    end else begin
      chk("retired", retired, exp_ret);
      if (wb_valid) begin
        exp_ret = exp_ret + 16'd1;
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", wb_valid, 1'b0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_fields", {wb_dst, wb_reg_write, wb_mem_to_reg}, {e.dst, e.rw, e.m2r});
          chk("wb_cycle", cyc, e.wb_cyc);
        end
      end else begin
        chk("wb_bubble", {wb_reg_write, wb_mem_to_reg, wb_dst}, 0);
      end
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", mem_valid, 1'b0);
        end else begin
          e = mem_q.pop_front();
          chk("mem_fields", {mem_dst, mem_read, mem_write, mem_branch, mem_jump},
              {e.dst, e.mr, e.mw, e.br, e.jp});
          chk("mem_cycle", cyc, e.wb_cyc - 1);
        end
      end else begin
        chk("mem_bubble", {mem_read, mem_write, mem_branch, mem_jump, mem_dst}, 0);
      end
    end
  end

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("reset_outs", all_outs(), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // R-type: rd selected, visible in EX one cycle after ID
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd1, 5'd2, 5'd5), 1'b1, 1'b0);
    push(mk(C_R, 2'b10, 5'd1, 5'd2, 5'd5), 5'd5, 3);
    next_cycle();
    idle();
    @(negedge clk);
    chk("ex_rtype", {ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op, ex_dst},
        {1'b1, 1'b1, 1'b0, 2'b10, 5'd5});
    drain(3);

    load_use("lu_rs8", mk(C_LW, 2'b00, 5'd3, 5'd8, 5'd9), 5'd8,
             mk(C_R, 2'b10, 5'd8, 5'd4, 5'd10), 5'd10, 1'b1);
    drain(3);
    load_use("lu_r0", mk(C_LW, 2'b00, 5'd3, 5'd0, 5'd0), 5'd0,
             mk(C_R, 2'b10, 5'd0, 5'd0, 5'd11), 5'd11, 1'b0);
    drain(3);
    load_use("lu_rt7", mk(C_LW, 2'b00, 5'd2, 5'd7, 5'd0), 5'd7,
             mk(C_SW, 2'b00, 5'd1, 5'd7, 5'd0), 5'd7, 1'b1);
    drain(3);

    // matching rs in an empty ID slot must not stall
    next_cycle();
    drive(mk(C_LW, 2'b00, 5'd1, 5'd12, 5'd0), 1'b1, 1'b0);
    push(mk(C_LW, 2'b00, 5'd1, 5'd12, 5'd0), 5'd12, 3);
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd12, 5'd12, 5'd1), 1'b0, 1'b0);
    @(negedge clk);
    chk("noid_stall", hazard_stall, 1'b0);
    drain(3);

    next_cycle();
    drive(mk(C_BEQ, 2'b01, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0);
    push(mk(C_BEQ, 2'b01, 5'd1, 5'd2, 5'd0), 5'd2, 3);
    next_cycle();
    drive(mk(C_J, 2'b00, 5'd0, 5'd3, 5'd0), 1'b1, 1'b0);
    push(mk(C_J, 2'b00, 5'd0, 5'd3, 5'd0), 5'd3, 3);
    drain(3);

    // flushed store never reaches MEM
    next_cycle();
    drive(mk(C_SW, 2'b00, 5'd2, 5'd3, 5'd0), 1'b1, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("flush_ex", {ex_valid, ex_alu_src, ex_dst}, 0);
    drain(3);

    // flush and load-use together: a single bubble
    next_cycle();
    drive(mk(C_LW, 2'b00, 5'd3, 5'd8, 5'd0), 1'b1, 1'b0);
    push(mk(C_LW, 2'b00, 5'd3, 5'd8, 5'd0), 5'd8, 3);
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd8, 5'd4, 5'd13), 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_haz_stall", hazard_stall, HAZ);
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd1, 5'd1, 5'd14), 1'b1, 1'b0);
    push(mk(C_R, 2'b10, 5'd1, 5'd1, 5'd14), 5'd14, 3);
    @(negedge clk);
    chk("flush_haz_ex", {ex_valid, ex_dst}, 0);
    drain(4);
    chk("retired_count", retired, n_issued[15:0]);
    chk("queues_empty", wb_q.size() + mem_q.size(), 0);

    // reset with EX, MEM and WB all occupied
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd1, 5'd2, 5'd20), 1'b1, 1'b0);
    push(mk(C_R, 2'b10, 5'd1, 5'd2, 5'd20), 5'd20, 3);
    next_cycle();
    drive(mk(C_SW, 2'b00, 5'd1, 5'd21, 5'd0), 1'b1, 1'b0);
    push(mk(C_SW, 2'b00, 5'd1, 5'd21, 5'd0), 5'd21, 3);
    next_cycle();
    drive(mk(C_LW, 2'b00, 5'd1, 5'd22, 5'd0), 1'b1, 1'b0);
    push(mk(C_LW, 2'b00, 5'd1, 5'd22, 5'd0), 5'd22, 3);
    next_cycle();
    drive(mk(C_R, 2'b10, 5'd22, 5'd22, 5'd23), 1'b1, 1'b0);
    #1;
    chk("pre_rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", all_outs(), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle();

    next_cycle();
    drive(mk(C_R, 2'b10, 5'd4, 5'd5, 5'd24), 1'b1, 1'b0);
    push(mk(C_R, 2'b10, 5'd4, 5'd5, 5'd24), 5'd24, 3);
    drain(4);
    chk("post_rst_retired", retired, 16'd1);

    // 65536 back-to-back retirements wrap the counter
    reset_pulse();
    for (int i = 0; i < 65536; i++) begin
      logic [4:0] rd;
      instr_t     ins;
      rd  = i[4:0];
      ins = mk({7'b1000_000, i[0]}, 2'b10, 5'd1, 5'd2, rd);
      next_cycle();
      drive(ins, 1'b1, 1'b0);
      push(ins, rd, 3);
    end
    drain(4);
    chk("retired_wrap", retired, 16'h0000);
    chk("queues_empty_end", wb_q.size() + mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
